truth_table_checker: RTL and testbench

- Hardware counterpart of the team's exhaustive 4-input stimulus sweep.
- Drives all 16 combinations of oA..oD into a combinational unit under test.
- Waits a programmable settle time per vector, then samples the unit's iY response into a 16-bit truth table.
- At the end of the sweep, compares the table against an expected constant and reports pass/fail, for on-chip self-test of small logic blocks.

---
 rtl/tt_pkg.sv | 20 ++
 rtl/tt_settle_timer.sv | 32 +++
 rtl/truth_table_checker.sv | 102 ++++++++++
 tb/tb_truth_table_checker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth table checker.
// Holds the FSM state type, vector/table widths and the settle counter width.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

    localparam int TT_VEC_W = 4;
    localparam int TT_TBL_W = 16;

    // A one-cycle settle still needs a one-bit counter.
    function automatic int tt_cnt_w(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times how long each stimulus vector is held.
// It reloads to SETTLE-1 on iLoad and stops at zero.
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iLoad,
    output logic oZero
);

    localparam int W = tt_cnt_w(SETTLE);
    localparam logic [W-1:0] LOAD = W'(SETTLE - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt <= '0;
        end else if (iLoad) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign oZero = (cnt == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all 16 input vectors into a small unit, captures its truth table and
// compares it to EXPECTED. Define TT_MISMATCH_CNT_EN for the mismatch counter.
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int                    SETTLE   = 2,
    parameter logic [TT_TBL_W-1:0]   EXPECTED = 16'h6996
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic                iY,
    output logic                oA,
    output logic                oB,
    output logic                oC,
    output logic                oD,
    output logic                oBusy,
    output logic                oDone,
    output logic                oPass,
    output logic [TT_TBL_W-1:0] oTable,
    output logic [4:0]          oErrCnt
);

    localparam logic [TT_VEC_W-1:0] LAST = '1;
    localparam logic [TT_VEC_W-1:0] VONE = TT_VEC_W'(1);

    tt_state_t           state;
    logic [TT_VEC_W-1:0] vec;
    logic                start;
    logic                load;
    logic                zero;

    // Start is only honoured when no sweep is running.
    assign start = iStart && (state == IDLE || state == DONE);
    assign load  = start || (state == SAMPLE);

    tt_settle_timer #(
        .SETTLE(SETTLE)
    ) u_timer (
        .iClk (iClk),
        .iRst (iRst),
        .iLoad(load),
        .oZero(zero)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state  <= IDLE;
            vec    <= '0;
            oTable <= '0;
            oPass  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (iStart) begin
                        vec    <= '0;
                        oTable <= '0;
                        oPass  <= 1'b0;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (zero) state <= SAMPLE;
                end
                SAMPLE: begin
                    oTable[vec] <= iY;
                    if (vec == LAST) begin
                        oPass <= ({iY, oTable[TT_TBL_W-2:0]} == EXPECTED);
                        state <= DONE;
                    end else begin
                        vec   <= vec + VONE;
                        state <= HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {oA, oB, oC, oD} = vec;
    assign oBusy = (state == HOLD) || (state == SAMPLE);
    assign oDone = (state == DONE);

`ifdef TT_MISMATCH_CNT_EN
    logic [4:0] err;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            err <= '0;
        end else if (start) begin
            err <= '0;
        end else if (state == SAMPLE && iY != EXPECTED[vec]) begin
            err <= err + 5'd1;
        end
    end

    assign oErrCnt = err;
`else
    assign oErrCnt = 5'd0;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: table-driven sweeps plus
// hand-written mid-sweep restart, reset and back-to-back sequences.
module tb_truth_table_checker;

    logic        clk;
    logic        iRst;
    logic        iStart;
    logic        iY;
    logic        oA, oB, oC, oD;
    logic        oBusy, oDone, oPass;
    logic [15:0] oTable;
    logic [4:0]  oErrCnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mode     = 0;
    logic [15:0] rnd      = '0;
    logic [3:0]  vec_now;

    localparam logic [15:0] GOLD = 16'h6996;
    localparam int          SWEEP_EDGES = 48;

    truth_table_checker dut (
        .iClk   (clk),
        .iRst   (iRst),
        .iStart (iStart),
        .iY     (iY),
        .oA     (oA),
        .oB     (oB),
        .oC     (oC),
        .oD     (oD),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oPass  (oPass),
        .oTable (oTable),
        .oErrCnt(oErrCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign vec_now = {oA, oB, oC, oD};

    // Simulated combinational unit under test.
    always @* begin
        case (mode)
            0:       iY = ^vec_now;
            1:       iY = &vec_now;
            2:       iY = |vec_now;
            default: iY = rnd[vec_now];
        endcase
    end

    function automatic logic [15:0] model_table(input int m, input logic [15:0] r);
        logic [15:0] t;
        t = '0;
        for (int v = 0; v < 16; v++) begin
            case (m)
                0:       t[v] = ($countones(v) % 2) == 1;
                1:       t[v] = (v == 15);
                2:       t[v] = (v != 0);
                default: t[v] = r[v];
            endcase
        end
        return t;
    endfunction

    function automatic logic [4:0] model_err(input logic [15:0] t);
`ifdef TT_MISMATCH_CNT_EN
        return 5'($countones(t ^ GOLD));
`else
        return 5'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(oBusy),   32'd0);
        check({tag, "_done"},  32'(oDone),   32'd0);
        check({tag, "_pass"},  32'(oPass),   32'd0);
        check({tag, "_table"}, 32'(oTable),  32'd0);
        check({tag, "_err"},   32'(oErrCnt), 32'd0);
        check({tag, "_vec"},   32'(vec_now), 32'd0);
    endtask

    // Start a sweep; optionally re-pulse start at inj_vec or reset at rst_vec.
    task automatic sweep(input int inj_vec, input int rst_vec, output int edges);
        bit injected;
        injected = 0;
        edges    = 0;
        @(negedge clk);
        iStart = 1'b1;
        @(posedge clk);
        #1;
        iStart = 1'b0;
        check("busy_after_start", 32'(oBusy), 32'd1);
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            iStart = 1'b0;
            if (oDone) begin
                edges = n;
                return;
            end
            if (!injected && int'(vec_now) == inj_vec) begin
                injected = 1;
                iStart   = 1'b1;
            end
            if (int'(vec_now) == rst_vec) begin
                #2;
                iRst = 1'b1;
                #1;
                check_idle("async_rst");
                @(negedge clk);
                iRst  = 1'b0;
                edges = -1;
                return;
            end
        end
        check("sweep_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        string       name;
        int          mode;
        logic [15:0] rnd;
        logic [15:0] exp_tbl;
        logic        exp_pass;
        logic [4:0]  exp_err;
    } vec_t;

    vec_t tv[6];

    initial begin
        int          edges;
        int          dones;
        int          last_done;
        logic [15:0] r;

        iRst   = 1'b1;
        iStart = 1'b0;

        tv[0] = '{"parity", 0, 16'h0, 16'h6996, 1'b1, model_err(16'h6996)};
        tv[1] = '{"and4",   1, 16'h0, 16'h8000, 1'b0, model_err(16'h8000)};
        tv[2] = '{"or4",    2, 16'h0, 16'hFFFE, 1'b0, model_err(16'hFFFE)};
        for (int i = 3; i < 5; i++) begin
            r = 16'($urandom);
            tv[i] = '{"random", 3, r, model_table(3, r), 1'b0, 5'd0};
            tv[i].exp_pass = (tv[i].exp_tbl == GOLD);
            tv[i].exp_err  = model_err(tv[i].exp_tbl);
        end
        r = GOLD ^ (16'd1 << $urandom_range(15));
        tv[5] = '{"one_bit_off", 3, r, model_table(3, r), 1'b0, model_err(r)};

        #12;
        iRst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_idle("reset");

        foreach (tv[i]) begin
            mode = tv[i].mode;
            rnd  = tv[i].rnd;
            sweep(-1, -1, edges);
            check({tv[i].name, "_edges"}, 32'(edges),   32'(SWEEP_EDGES));
            check({tv[i].name, "_table"}, 32'(oTable),  32'(tv[i].exp_tbl));
            check({tv[i].name, "_pass"},  32'(oPass),   32'(tv[i].exp_pass));
            check({tv[i].name, "_err"},   32'(oErrCnt), 32'(tv[i].exp_err));
            check({tv[i].name, "_busy"},  32'(oBusy),   32'd0);
            check({tv[i].name, "_vec"},   32'(vec_now), 32'hF);
            repeat (3) @(posedge clk);
            #1;
            check({tv[i].name, "_done_held"},  32'(oDone),  32'd1);
            check({tv[i].name, "_table_held"}, 32'(oTable), 32'(tv[i].exp_tbl));
        end

        // Restart request mid-sweep must be ignored.
        mode = 0;
        sweep(5, -1, edges);
        check("inject_edges", 32'(edges),  32'(SWEEP_EDGES));
        check("inject_table", 32'(oTable), 32'(GOLD));
        check("inject_pass",  32'(oPass),  32'd1);

        // Asynchronous reset at vector 9, then a clean sweep.
        sweep(-1, 9, edges);
        check("rst_sweep_aborted", 32'(edges), 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        check_idle("after_rst");
        sweep(-1, -1, edges);
        check("post_rst_edges", 32'(edges),  32'(SWEEP_EDGES));
        check("post_rst_table", 32'(oTable), 32'(GOLD));
        check("post_rst_pass",  32'(oPass),  32'd1);

        // Continuous start: DONE visible one cycle every 49 cycles.
        @(negedge clk);
        iStart    = 1'b1;
        dones     = 0;
        last_done = 0;
        for (int c = 1; c <= 160; c++) begin
            @(posedge clk);
            #1;
            if (oDone) begin
                dones++;
                check("cont_table", 32'(oTable), 32'(GOLD));
                if (last_done != 0)
                    check("cont_gap", 32'(c - last_done), 32'd49);
                last_done = c;
            end else if (last_done != 0 && c == last_done + 1) begin
                check("cont_restart_cleared", 32'(oTable), 32'd0);
                check("cont_restart_busy",    32'(oBusy),  32'd1);
            end
        end
        iStart = 1'b0;
        check("cont_done_count", 32'(dones), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
